// File: rtl/grant_decoder_pkg.sv
// Shared widths and state encoding for the 2->4 grant decoder.
package grant_decoder_pkg;
  localparam int CODE_W = 2;
  localparam int GNT_W  = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
endpackage

// File: rtl/two_to_four_decoder_core.sv
// Combinational 2->4 one-hot decode; bit order matches the encoder inputs (a..d).
module two_to_four_decoder_core
  import grant_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [GNT_W-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    case (code_i)
      2'd0:    onehot_o = 4'b0001;
      2'd1:    onehot_o = 4'b0010;
      2'd2:    onehot_o = 4'b0100;
      default: onehot_o = 4'b1000;
    endcase
  end

endmodule

// File: rtl/two_to_four_grant_decoder.sv
// Accepts encoded request indices and holds the matching one-hot grant for HOLD_CYCLES,
// with a one-entry buffer so consecutive grants follow each other without a gap.
module two_to_four_grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  // Handshake: a code transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on the buffer flag, never on in_valid.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [GNT_W-1:0]  grant,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic              state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_full_q, buf_full_d;
  logic [CODE_W-1:0] buf_code_q, buf_code_d;
  logic [GNT_W-1:0]  grant_q, grant_d;
  logic              xfer;
  logic              last_cycle;
  logic              load;
  logic [CODE_W-1:0] load_code;
  logic [GNT_W-1:0]  dec_onehot;

  assign in_ready   = !buf_full_q;
  assign xfer       = in_valid && in_ready;
  assign last_cycle = (state_q == ST_GRANT) && (cnt_q == '0);
  // A full buffer always wins; otherwise the incoming code is the only candidate.
  assign load_code  = buf_full_q ? buf_code_q : in_code;

  two_to_four_decoder_core u_core (
    .code_i   (load_code),
    .onehot_o (dec_onehot)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_code_d = buf_code_q;
    grant_d    = grant_q;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_GRANT;
          load    = 1'b1;
        end
      end
      default: begin
        if (!last_cycle) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (xfer) begin
            buf_full_d = 1'b1;
            buf_code_d = in_code;
          end
        end else if (buf_full_q) begin
          load       = 1'b1;
          buf_full_d = 1'b0;
        end else if (xfer) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
    endcase
    if (load) begin
      grant_d = dec_onehot;
      cnt_d   = RELOAD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      buf_code_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      buf_code_q <= buf_code_d;
      grant_q    <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_GRANT);
  assign done  = last_cycle;

endmodule

// File: tb/tb_two_to_four_grant_decoder.sv
// Bench for two_to_four_grant_decoder: a per-cycle expected grant schedule is built from
// accepted codes and compared against the DUT outputs on every falling edge.
module tb_two_to_four_grant_decoder;
  localparam int HOLD = 4;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic [3:0] grant;
  logic       busy;
  logic       done;

  // Each entry is one future grant cycle: {last_cycle_of_episode, grant}.
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  two_to_four_grant_decoder #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .grant    (grant),
    .busy     (busy),
    .done     (done)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; if the transfer will happen at the coming edge,
  // append HOLD grant cycles of the decoded code to the schedule.
  task automatic step(input bit v, input logic [1:0] code);
    logic [3:0] g;
    logic       last;
    in_valid = v;
    in_code  = code;
    // Schedule entries left after the current cycle; at HOLD or more a code is already waiting.
    if (v && reset_n && exp_q.size() < HOLD) begin
      g = 4'b0001 << code;
      for (int i = 0; i < HOLD; i++) begin
        last = (i == HOLD - 1);
        exp_q.push_back({last, g});
      end
    end
    @(negedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [4:0] e;
    logic       exp_rdy;
    e       = 5'b0;
    exp_rdy = (exp_q.size() <= HOLD);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("grant", 32'(grant), 32'(e[3:0]));
    check("busy", 32'(busy), 32'(e[3:0] != 4'b0));
    check("done", 32'(done), 32'(e[4]));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_code  = 2'd0;
    repeat (4) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    reset_n = 1'b1;

    // single request
    step(1'b1, 2'd2);
    repeat (6) step(1'b0, 2'd0);

    // decode sweep with idle gaps
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 2'(c));
      repeat (5) step(1'b0, 2'd0);
    end

    // back-to-back: second code buffered, further valid held off
    step(1'b1, 2'd1);
    step(1'b1, 2'd3);
    repeat (3) step(1'b1, 2'($urandom_range(0, 3)));
    repeat (9) step(1'b0, 2'd0);

    // bypass during the done cycle
    step(1'b1, 2'd2);
    repeat (3) step(1'b0, 2'd0);
    step(1'b1, 2'd0);
    repeat (6) step(1'b0, 2'd0);

    // reset during grant cycle 2 with the buffer full
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    exp_q.delete();
    in_valid = 1'b1;
    in_code  = 2'($urandom_range(0, 3));
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) step(1'b0, 2'd0);
    step(1'b1, 2'd2);
    repeat (6) step(1'b0, 2'd0);

    // randomized traffic
    repeat (400) step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
    repeat (12) step(1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
